// File: rtl/multicycle_control_pkg.sv
// Shared types for the multicycle controller: FSM states, opcodes, datapath select
// encodings, and the per-state Moore decode.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAddr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecute,
    StAluWb,
    StBranch,
    StTrap
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  typedef enum logic [1:0] {
    AluAdd   = 2'b00,
    AluSub   = 2'b01,
    AluFunct = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SrcBReg  = 2'b00,
    SrcBFour = 2'b01,
    SrcBImm  = 2'b10
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ImmI    = 2'b00,
    ImmS    = 2'b01,
    ImmB    = 2'b10,
    ImmNone = 2'b11
  } imm_sel_e;

  // State-decoded control word; mem_ready-gated strobes are handled outside it.
  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       pc_write_cond;
    logic       pc_source;
    logic       retire;
    logic       trap;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
  } ctrl_t;

  function automatic ctrl_t moore_decode(input state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      StFetch: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SrcBFour;
        c.alu_op    = AluAdd;
      end
      StDecode: begin
        c.alu_src_b = SrcBImm;
        c.alu_op    = AluAdd;
      end
      StMemAddr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBImm;
        c.alu_op    = AluAdd;
      end
      StMemRead: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      StMemWb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.retire     = 1'b1;
      end
      StMemWrite: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      StExecute: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBReg;
        c.alu_op    = AluFunct;
      end
      StAluWb: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      StBranch: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SrcBReg;
        c.alu_op        = AluSub;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
        c.retire        = 1'b1;
      end
      StTrap: c.trap = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic imm_sel_e imm_sel_for(input logic [6:0] op);
    case (op)
      OpLoad:   return ImmI;
      OpStore:  return ImmS;
      OpBranch: return ImmB;
      default:  return ImmNone;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             ir_write;
  logic             mem_read;
  logic             mem_write;
  logic             i_or_d;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic             pc_source;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       imm_sel;
  logic             retire;
  logic [CNT_W-1:0] retired_count;
  logic             trap;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, mem_to_reg,
           reg_write, alu_src_a, pc_source, alu_src_b, alu_op, imm_sel, retire,
           retired_count, trap
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d, mem_to_reg,
           reg_write, alu_src_a, pc_source, alu_src_b, alu_op, imm_sel, retire,
           retired_count, trap
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles; expired flags the last allowed stall cycle.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  output logic expired
);
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  // cnt_q holds stall cycles already elapsed, so the TIMEOUT-th stall sees Last.
  // A ready in that same cycle suppresses expiry: completion wins.
  assign expired = waiting & ~mem_ready & (cnt_q == Last);

  // Stall counter; any completion or leaving a wait state restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (!waiting || mem_ready) begin
      cnt_q <= '0;
    end else if (!expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/multicycle_control.sv
// Multicycle load/store/R-type/branch controller with memory timeout trap and
// retired-instruction counter.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 32
) (
  input logic                clk,
  input logic                reset,
  multicycle_control_if.master bus
);
  state_e           state_q, state_d;
  ctrl_t            ctrl_q;
  logic             waiting, expired;
  logic             fetch_done, store_done, retire;
  logic [CNT_W-1:0] count_q;
  logic             unused_zero;

  // zero is consumed by the datapath's pc_write_cond AND, not by the controller.
  assign unused_zero = bus.zero;

  assign waiting = state_q inside {StFetch, StMemRead, StMemWrite};

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_mem_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .waiting  (waiting),
    .mem_ready(bus.mem_ready),
    .expired  (expired)
  );

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (bus.mem_ready)  state_d = StDecode;
        else if (expired)   state_d = StTrap;
      end
      StDecode: begin
        if (bus.opcode == OpLoad || bus.opcode == OpStore) state_d = StMemAddr;
        else if (bus.opcode == OpRtype)                    state_d = StExecute;
        else if (bus.opcode == OpBranch)                   state_d = StBranch;
        else                                               state_d = StTrap;
      end
      StMemAddr: state_d = (bus.opcode == OpStore) ? StMemWrite : StMemRead;
      StMemRead: begin
        if (bus.mem_ready)  state_d = StMemWb;
        else if (expired)   state_d = StTrap;
      end
      StMemWrite: begin
        if (bus.mem_ready)  state_d = StFetch;
        else if (expired)   state_d = StTrap;
      end
      StExecute: state_d = StAluWb;
      StMemWb, StAluWb, StBranch: state_d = StFetch;
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase
  end

  // State register plus registered Moore control word for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      ctrl_q  <= moore_decode(StFetch);
    end else begin
      state_q <= state_d;
      ctrl_q  <= moore_decode(state_d);
    end
  end

  // Strobes that depend on this cycle's memory completion; reset masks them at once.
  assign fetch_done = (state_q == StFetch)    & bus.mem_ready & ~reset;
  assign store_done = (state_q == StMemWrite) & bus.mem_ready & ~reset;
  assign retire     = (ctrl_q.retire | store_done) & ~reset;

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign bus.pc_write      = fetch_done;
  assign bus.ir_write      = fetch_done;
  assign bus.pc_write_cond = ctrl_q.pc_write_cond;
  assign bus.pc_source     = ctrl_q.pc_source;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write & ~reset;
  assign bus.i_or_d        = ctrl_q.i_or_d;
  assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
  assign bus.reg_write     = ctrl_q.reg_write & ~reset;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.alu_op        = ctrl_q.alu_op;
  assign bus.imm_sel       = imm_sel_for(bus.opcode);
  assign bus.retire        = retire;
  assign bus.retired_count = count_q;
  assign bus.trap          = ctrl_q.trap;
endmodule
